// File: rtl/char_pkg.sv
// Shared character-cell geometry, FSM state encoding and colour width for
// the text plotting path.
package char_pkg;
   localparam int CHAR_W  = 8;
   localparam int CHAR_H  = 10;
   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;
   localparam int COL_W   = 6;
   localparam int PX_W    = $clog2(CHAR_W);
   localparam int PY_W    = $clog2(CHAR_H);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SCAN   = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_e;
endpackage

// File: rtl/text_plotter_scan.sv
// Pixel/row/character counters for the cell raster walk; px fastest, then
// py, then ci. Flags the final pixel of the final character.
module text_plotter_scan
   import char_pkg::*;
(
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             step_i,
   input  logic [LEN_W-1:0] len_i,
   output logic [PX_W-1:0]  px_o,
   output logic [PY_W-1:0]  py_o,
   output logic [LEN_W-1:0] ci_o,
   output logic             last_o
);
   logic [PX_W-1:0]  px_q, px_d;
   logic [PY_W-1:0]  py_q, py_d;
   logic [LEN_W-1:0] ci_q, ci_d;
   logic             px_end, py_end;

   assign px_end = (px_q == PX_W'(CHAR_W - 1));
   assign py_end = (py_q == PY_W'(CHAR_H - 1));
   assign last_o = px_end && py_end && (ci_q == len_i - LEN_W'(1));

   always_comb begin
      px_d = px_q;
      py_d = py_q;
      ci_d = ci_q;
      if (clear_i) begin
         px_d = '0;
         py_d = '0;
         ci_d = '0;
      end else if (step_i) begin
         // Returning to zero after the last pixel leaves the query outputs idle.
         if (last_o) begin
            px_d = '0;
            py_d = '0;
            ci_d = '0;
         end else if (px_end) begin
            px_d = '0;
            if (py_end) begin
               py_d = '0;
               ci_d = ci_q + LEN_W'(1);
            end else begin
               py_d = py_q + PY_W'(1);
            end
         end else begin
            px_d = px_q + PX_W'(1);
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         px_q <= '0;
         py_q <= '0;
         ci_q <= '0;
      end else begin
         px_q <= px_d;
         py_q <= py_d;
         ci_q <= ci_d;
      end
   end

   assign px_o = px_q;
   assign py_o = py_q;
   assign ci_o = ci_q;
endmodule

// File: rtl/text_plotter.sv
// Rasterizes a string of 8x10 glyph cells into framebuffer plot writes,
// one pixel per cycle, via an external combinational glyph decoder.
module text_plotter
   import char_pkg::*;
(
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [7:0]       origin_x_i,
   input  logic [7:0]       origin_y_i,
   input  logic [LEN_W-1:0] str_len_i,
   input  logic             opaque_i,
   input  logic [COL_W-1:0] bg_colour_i,
   output logic [LEN_W-1:0] char_idx_o,
   input  logic [7:0]       char_code_i,
   output logic [7:0]       glyph_code_o,
   output logic [7:0]       glyph_x_o,
   output logic [7:0]       glyph_y_o,
   input  logic [COL_W-1:0] glyph_colour_i,
   input  logic             glyph_enable_i,
   output logic [7:0]       plot_x_o,
   output logic [7:0]       plot_y_o,
   output logic [COL_W-1:0] plot_colour_o,
   output logic             plot_o,
   output logic             busy_o,
   output logic             done_o
);
   state_e           state_q, state_d;
   logic [7:0]       origin_x_q, origin_y_q;
   logic [LEN_W-1:0] len_q, len_clamped;
   logic             opaque_q;
   logic [COL_W-1:0] bg_q;
   logic             accept, scanning, last;
   logic [PX_W-1:0]  px;
   logic [PY_W-1:0]  py;
   logic [LEN_W-1:0] ci;

   logic             plot_q, plot_d;
   logic [7:0]       plot_x_q, plot_x_d, plot_y_q, plot_y_d;
   logic [COL_W-1:0] plot_colour_q, plot_colour_d;

   assign accept      = (state_q == S_IDLE) && start_i;
   assign scanning    = (state_q == S_SCAN);
   assign len_clamped = (str_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : str_len_i;

   text_plotter_scan u_scan (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .clear_i (accept),
      .step_i  (scanning),
      .len_i   (len_q),
      .px_o    (px),
      .py_o    (py),
      .ci_o    (ci),
      .last_o  (last)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         // An empty string still takes the drain cycle so done timing is uniform.
         S_IDLE:   if (start_i) state_d = (len_clamped == '0) ? S_DRAIN : S_SCAN;
         S_SCAN:   if (last) state_d = S_DRAIN;
         S_DRAIN:  state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      plot_d        = scanning && (glyph_enable_i || opaque_q);
      plot_colour_d = glyph_enable_i ? glyph_colour_i : bg_q;
      plot_x_d      = origin_x_q + 8'(ci) * 8'(CHAR_W) + 8'(px);
      plot_y_d      = origin_y_q + 8'(py);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         origin_x_q    <= '0;
         origin_y_q    <= '0;
         len_q         <= '0;
         opaque_q      <= 1'b0;
         bg_q          <= '0;
         plot_q        <= 1'b0;
         plot_x_q      <= '0;
         plot_y_q      <= '0;
         plot_colour_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            origin_x_q <= origin_x_i;
            origin_y_q <= origin_y_i;
            len_q      <= len_clamped;
            opaque_q   <= opaque_i;
            bg_q       <= bg_colour_i;
         end
         plot_q <= plot_d;
         if (plot_d) begin
            plot_x_q      <= plot_x_d;
            plot_y_q      <= plot_y_d;
            plot_colour_q <= plot_colour_d;
         end
      end
   end

   assign char_idx_o    = ci;
   assign glyph_code_o  = char_code_i;
   assign glyph_x_o     = 8'(px);
   assign glyph_y_o     = 8'(py);
   assign plot_o        = plot_q;
   assign plot_x_o      = plot_x_q;
   assign plot_y_o      = plot_y_q;
   assign plot_colour_o = plot_colour_q;
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_FINISH);
endmodule

// File: tb/tb_text_plotter.sv
// Directed bench for text_plotter with a stub glyph decoder and string buffer.
module tb_text_plotter;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] origin_x = '0, origin_y = '0;
   logic [4:0] str_len = '0;
   logic       opaque = 1'b0;
   logic [5:0] bg_colour = '0;
   logic [4:0] char_idx;
   logic [7:0] char_code, glyph_code, glyph_x, glyph_y;
   logic [5:0] glyph_colour;
   logic       glyph_enable;
   logic [7:0] plot_x, plot_y;
   logic [5:0] plot_colour;
   logic       plot, busy, done;

   int n_chk = 0, n_fail = 0;
   int mode = 0;  // 0 off, 1 two-pixel stub, 2 all on
   int qx[$], qy[$], qc[$];
   int idx_at[0:300];
   int code_at[0:300];
   int post_rst_plots;
   int lat;

   always #5 clock = ~clock;

   text_plotter dut (
      .clock_i(clock), .reset_i(reset), .start_i(start),
      .origin_x_i(origin_x), .origin_y_i(origin_y), .str_len_i(str_len),
      .opaque_i(opaque), .bg_colour_i(bg_colour),
      .char_idx_o(char_idx), .char_code_i(char_code), .glyph_code_o(glyph_code),
      .glyph_x_o(glyph_x), .glyph_y_o(glyph_y),
      .glyph_colour_i(glyph_colour), .glyph_enable_i(glyph_enable),
      .plot_x_o(plot_x), .plot_y_o(plot_y), .plot_colour_o(plot_colour),
      .plot_o(plot), .busy_o(busy), .done_o(done)
   );

   assign char_code    = 8'h41 + 8'(char_idx);
   assign glyph_colour = 6'h3F;
   always_comb begin
      glyph_enable = 1'b0;
      if (mode == 2) glyph_enable = 1'b1;
      else if (mode == 1)
         glyph_enable = (glyph_x == 8'd2 && glyph_y == 8'd0) || (glyph_x == 8'd7 && glyph_y == 8'd9);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic do_start(input int ox, input int oy, input int len, input int opq, input int bg);
      @(negedge clock);
      origin_x  = 8'(ox);
      origin_y  = 8'(oy);
      str_len   = 5'(len);
      opaque    = opq[0];
      bg_colour = 6'(bg);
      start     = 1'b1;
   endtask

   // inj_kind: 0 none, 1 restart with a new origin, 2 reset
   task automatic run(input int limit, input int inj_n, input int inj_kind, output int l);
      l = -1;
      qx.delete(); qy.delete(); qc.delete();
      post_rst_plots = 0;
      for (int n = 1; n <= limit; n++) begin
         @(negedge clock);
         start = 1'b0;
         if (plot) begin
            qx.push_back(int'(plot_x));
            qy.push_back(int'(plot_y));
            qc.push_back(int'(plot_colour));
            if (inj_kind == 2 && n > inj_n) post_rst_plots++;
         end
         if (n <= 300) begin
            idx_at[n]  = int'(char_idx);
            code_at[n] = int'(glyph_code);
         end
         if (inj_kind == 2 && n == inj_n + 1) begin
            chk("rst_plot", int'(plot), 0);
            chk("rst_busy", int'(busy), 0);
            reset = 1'b0;
         end
         if (done) begin
            l = n;
            break;
         end
         if (n == inj_n && inj_kind == 1) begin
            start = 1'b1; origin_x = 8'd100; origin_y = 8'd100;
         end
         if (n == inj_n && inj_kind == 2) reset = 1'b1;
      end
   endtask

   task automatic after_done(input string tag);
      @(negedge clock);
      chk({tag, "_busy_after"}, int'(busy), 0);
      chk({tag, "_done_after"}, int'(done), 0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk("reset_plot", int'(plot), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_px", int'(plot_x), 0);
      chk("reset_idx", int'(char_idx), 0);

      // Reset mid-draw
      mode = 2;
      do_start(10, 20, 2, 0, 0);
      run(200, 40, 2, lat);
      chk("rst_nodone", lat, -1);
      chk("rst_noplot_after", post_rst_plots, 0);

      // Single char, transparent
      mode = 1;
      do_start(10, 20, 1, 0, 0);
      run(200, 0, 0, lat);
      chk("t2_latency", lat, 82);
      chk("t2_nplots", qx.size(), 2);
      if (qx.size() == 2) begin
         chk("t2_p0x", qx[0], 12); chk("t2_p0y", qy[0], 20); chk("t2_p0c", qc[0], 'h3F);
         chk("t2_p1x", qx[1], 17); chk("t2_p1y", qy[1], 29); chk("t2_p1c", qc[1], 'h3F);
      end
      after_done("t2");

      // Opaque fill
      do_start(10, 20, 1, 1, 1);
      run(200, 0, 0, lat);
      chk("t3_latency", lat, 82);
      chk("t3_nplots", qx.size(), 80);
      if (qx.size() == 80) begin
         chk("t3_p0x", qx[0], 10); chk("t3_p0y", qy[0], 20); chk("t3_p0c", qc[0], 1);
         chk("t3_p2x", qx[2], 12); chk("t3_p2c", qc[2], 'h3F);
         chk("t3_p8x", qx[8], 10); chk("t3_p8y", qy[8], 21); chk("t3_p8c", qc[8], 1);
         chk("t3_p79x", qx[79], 17); chk("t3_p79y", qy[79], 29); chk("t3_p79c", qc[79], 'h3F);
      end
      after_done("t3");
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("t3_done_once", int'(done), 0);
      end

      // Multi-char advance
      mode = 2;
      do_start(0, 0, 3, 0, 0);
      run(400, 0, 0, lat);
      chk("t4_latency", lat, 242);
      chk("t4_nplots", qx.size(), 240);
      if (qx.size() == 240) begin
         chk("t4_p80x", qx[80], 8); chk("t4_p80y", qy[80], 0);
         chk("t4_p239x", qx[239], 23); chk("t4_p239y", qy[239], 9);
      end
      chk("t4_idx80", idx_at[80], 0);
      chk("t4_idx81", idx_at[81], 1);
      chk("t4_idx161", idx_at[161], 2);
      chk("t4_code81", code_at[81], 'h42);

      // Wrap and clamp
      do_start(250, 5, 1, 0, 0);
      run(200, 0, 0, lat);
      chk("t5_nplots", qx.size(), 80);
      if (qx.size() == 80) begin
         chk("t5_p5x", qx[5], 255); chk("t5_p6x", qx[6], 0); chk("t5_p7x", qx[7], 1);
      end
      do_start(0, 0, 31, 0, 0);
      run(1500, 0, 0, lat);
      chk("t5_clamp_latency", lat, 1282);
      chk("t5_clamp_nplots", qx.size(), 1280);

      // len=0
      do_start(0, 0, 0, 1, 0);
      run(20, 0, 0, lat);
      chk("t6_len0_latency", lat, 2);
      chk("t6_len0_nplots", qx.size(), 0);
      after_done("t6_len0");

      // start while busy
      do_start(10, 20, 1, 0, 0);
      run(200, 20, 1, lat);
      chk("t6_busy_latency", lat, 82);
      chk("t6_busy_nplots", qx.size(), 80);
      if (qx.size() == 80) begin
         chk("t6_p30x", qx[30], 16); chk("t6_p30y", qy[30], 23);
         chk("t6_p79x", qx[79], 17); chk("t6_p79y", qy[79], 29);
      end
      after_done("t6_busy");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
